// File: rtl/ans_ht_ltf_deobf.sv
// HT-LTF de-obfuscation: captures one 64-subcarrier symbol, rescales each I/Q pair by its
// 2-bit code, then streams it out with valid/ready. Define ANS_DEOBF_SAT_EN for saturation + ovf.
module ans_ht_ltf_deobf #(
  parameter int IQ_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [127:0]      obf_coeff,
  input  logic [2*IQ_W-1:0] in_data,
  input  logic              in_valid,
  output logic [2*IQ_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              ovf
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    EMIT
  } state_t;

  state_t            state_q, state_d;
  logic [6:0]        idx_q, idx_d;
  logic [127:0]      coeff_q, coeff_d;
  logic              wr_en;
  logic [1:0]        code;
  logic [2*IQ_W-1:0] scaled;
  logic [2*IQ_W-1:0] buf_mem [64];

  assign code = coeff_q[{idx_q[5:0], 1'b0} +: 2];

`ifdef ANS_DEOBF_SAT_EN
  // Returns {overflow, value}; the product is widened by 3 bits so x8 can never lose sign.
  function automatic logic [IQ_W:0] scale_comp(input logic [IQ_W-1:0] x, input logic [1:0] c);
    logic signed [IQ_W+2:0] prod;
    prod = {{3{x[IQ_W-1]}}, x};
    case (c)
      2'b01:   prod = prod <<< 3;
      2'b10:   prod = prod <<< 1;
      2'b11:   prod = prod <<< 2;
      default: prod = prod;
    endcase
    if ((prod[IQ_W+2:IQ_W-1] == '0) || (prod[IQ_W+2:IQ_W-1] == '1))
      return {1'b0, prod[IQ_W-1:0]};
    else if (prod[IQ_W+2])
      return {1'b1, 1'b1, {(IQ_W-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(IQ_W-1){1'b1}}};
  endfunction

  logic [IQ_W:0] res_i, res_q;
  logic          ovf_q;

  assign res_i  = scale_comp(in_data[2*IQ_W-1:IQ_W], code);
  assign res_q  = scale_comp(in_data[IQ_W-1:0], code);
  assign scaled = {res_i[IQ_W-1:0], res_q[IQ_W-1:0]};

  always_ff @(posedge clk) begin
    if (reset)
      ovf_q <= 1'b0;
    else if (state_q == IDLE && start)
      ovf_q <= 1'b0;
    else if (wr_en && (res_i[IQ_W] || res_q[IQ_W]))
      ovf_q <= 1'b1;
  end

  assign ovf = ovf_q;
`else
  // Plain shifts in IQ_W bits give the wrap-around result directly.
  function automatic logic [IQ_W-1:0] scale_comp(input logic [IQ_W-1:0] x, input logic [1:0] c);
    case (c)
      2'b01:   return x << 3;
      2'b10:   return x << 1;
      2'b11:   return x << 2;
      default: return x;
    endcase
  endfunction

  assign scaled = {scale_comp(in_data[2*IQ_W-1:IQ_W], code), scale_comp(in_data[IQ_W-1:0], code)};
  assign ovf    = 1'b0;
`endif

  // NOTE: every signal is given a default before the case so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    coeff_d   = coeff_q;
    wr_en     = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          coeff_d = obf_coeff;
          idx_d   = '0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (idx_q == 7'd63) begin
            idx_d   = '0;
            state_d = EMIT;
          end else begin
            idx_d = idx_q + 7'd1;
          end
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        out_last  = (idx_q == 7'd63);
        out_data  = buf_mem[idx_q[5:0]];
        if (out_ready) begin
          if (idx_q == 7'd63) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 7'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      coeff_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      coeff_q <= coeff_d;
    end
  end

  // NOTE: the buffer has no reset; all 64 entries are rewritten before EMIT can read any.
  always_ff @(posedge clk) begin
    if (wr_en)
      buf_mem[idx_q[5:0]] <= scaled;
  end

endmodule

// File: tb/tb_ans_ht_ltf_deobf.sv
// Self-checking bench for ans_ht_ltf_deobf: randomized symbols against an arithmetic model
// of the per-subcarrier scaling, with stalls, gaps, resets and ignored starts.
module tb_ans_ht_ltf_deobf;
  localparam int IQ_W = 16;

  logic              clk;
  logic              reset;
  logic              start;
  logic [127:0]      obf_coeff;
  logic [2*IQ_W-1:0] in_data;
  logic              in_valid;
  logic [2*IQ_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              ovf;

  ans_ht_ltf_deobf #(.IQ_W(IQ_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .obf_coeff(obf_coeff),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] sym_coeff;
  logic [31:0]  sym_data [64];
  logic [31:0]  exp_data [64];
  logic         exp_ovf;

  // Reference: value = signed component times 1/8/2/4, then clamp (saturating build) or keep low 16 bits.
  function automatic logic [16:0] model_comp(input logic [15:0] x, input logic [1:0] c);
    int v;
    int f;
    f = (c == 2'b00) ? 1 : (c == 2'b01) ? 8 : (c == 2'b10) ? 2 : 4;
    v = int'($signed(x)) * f;
`ifdef ANS_DEOBF_SAT_EN
    if (v > 32767)  return {1'b1, 16'h7FFF};
    if (v < -32768) return {1'b1, 16'h8000};
`endif
    return {1'b0, v[15:0]};
  endfunction

  task automatic build_expected();
    logic [16:0] ri, rq;
    exp_ovf = 1'b0;
    for (int k = 0; k < 64; k++) begin
      ri = model_comp(sym_data[k][31:16], sym_coeff[2*k +: 2]);
      rq = model_comp(sym_data[k][15:0],  sym_coeff[2*k +: 2]);
      exp_data[k] = {ri[15:0], rq[15:0]};
      exp_ovf     = exp_ovf | ri[16] | rq[16];
    end
  endtask

  function automatic logic [127:0] rand_coeff();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // in_mode: 0 continuous, 1 every other cycle, 2 random. rdy_mode: 0 always, 1 random, 2 stall 3 at idx 10.
  task automatic run_symbol(input string tag, input int in_mode, input int rdy_mode, input bit inject_start);
    int   k, n, cyc, stall_cnt;
    bit   tog, v, r, injected, stalled;
    logic [31:0] held;
    build_expected();
    @(negedge clk);
    start     = 1'b1;
    obf_coeff = sym_coeff;
    in_valid  = 1'b1;
    in_data   = $urandom;
    @(negedge clk);
    start     = 1'b0;
    obf_coeff = rand_coeff();
    n_checks++;
    if (busy !== 1'b1 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL %s armed: busy=%b ovf=%b, required busy=1 ovf=0", tag, busy, ovf);
    end
    k = 0; tog = 1'b0; cyc = 0;
    while (k < 64 && cyc < 2000) begin
      cyc++;
      case (in_mode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = ~tog; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_data  = v ? sym_data[k] : $urandom;
      @(negedge clk);
      if (v) k++;
      if (k < 64) begin
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0) begin
          n_fail++;
          $display("FAIL %s collect_idle k=%0d: valid=%b last=%b data=%h, required 0/0/0", tag, k, out_valid, out_last, out_data);
        end
      end
    end
    n = 0; cyc = 0; stall_cnt = 0; injected = 1'b0; stalled = 1'b0; held = '0;
    while (n < 64 && cyc < 2000) begin
      cyc++;
      n_checks++;
      if (out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL %s out_valid n=%0d: got %b, required 1", tag, n, out_valid);
      end else begin
        n_checks++;
        if (out_data !== exp_data[n]) begin
          n_fail++;
          $display("FAIL %s out_data n=%0d: got %h, required %h", tag, n, out_data, exp_data[n]);
        end
        n_checks++;
        if (out_last !== (n == 63)) begin
          n_fail++;
          $display("FAIL %s out_last n=%0d: got %b, required %b", tag, n, out_last, (n == 63));
        end
        if (stalled) begin
          n_checks++;
          if (out_data !== held) begin
            n_fail++;
            $display("FAIL %s stall_hold n=%0d: got %h, required %h", tag, n, out_data, held);
          end
        end
      end
      case (rdy_mode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(0, 3) != 0);
        default: begin
          r = !(n == 10 && stall_cnt < 3);
          if (!r) stall_cnt++;
        end
      endcase
      out_ready = r;
      if (inject_start && n == 20 && !injected) begin
        start     = 1'b1;
        obf_coeff = ~sym_coeff;
        injected  = 1'b1;
      end
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      held     = out_data;
      stalled  = !r;
      @(negedge clk);
      start = 1'b0;
      if (r) n++;
    end
    n_checks++;
    if (n < 64) begin
      n_fail++;
      $display("FAIL %s emit_timeout: got %0d transfers, required 64", tag, n);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL %s end_idle: valid=%b busy=%b last=%b data=%h, required all 0", tag, out_valid, busy, out_last, out_data);
    end
    n_checks++;
    if (ovf !== exp_ovf) begin
      n_fail++;
      $display("FAIL %s ovf: got %b, required %b", tag, ovf, exp_ovf);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; obf_coeff = '0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 || busy !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b last=%b data=%h busy=%b ovf=%b, required all 0", out_valid, out_last, out_data, busy, ovf);
    end
    in_valid = 1'b1;
    in_data  = $urandom;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignores_valid: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_identity();
    logic [15:0] kk;
    sym_coeff = '0;
    for (int k = 0; k < 64; k++) begin
      kk = 16'(k);
      sym_data[k] = {kk, -kk};
    end
    run_symbol("identity", 0, 0, 1'b0);
  endtask

  task automatic test_codes();
    logic [127:0] c;
    for (int code = 1; code < 4; code++) begin
      c = '0;
      for (int k = 0; k < 64; k++) c[2*k +: 2] = 2'(code);
      sym_coeff = c;
      for (int k = 0; k < 64; k++) sym_data[k] = 32'h0100_FF00;
      run_symbol($sformatf("code%0d", code), 0, 0, 1'b0);
    end
  endtask

  task automatic test_overflow();
    sym_coeff = '0;
    sym_coeff[11:10] = 2'b01;
    for (int k = 0; k < 64; k++) sym_data[k] = 32'h2000_E000;
    run_symbol("overflow", 0, 0, 1'b0);
  endtask

  task automatic test_stall();
    sym_coeff = rand_coeff();
    for (int k = 0; k < 64; k++) sym_data[k] = $urandom;
    run_symbol("stall", 1, 2, 1'b0);
  endtask

  task automatic test_random();
    for (int s = 0; s < 3; s++) begin
      sym_coeff = rand_coeff();
      for (int k = 0; k < 64; k++) sym_data[k] = $urandom;
      run_symbol($sformatf("random%0d", s), 2, 1, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1;
    obf_coeff = rand_coeff();
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      in_valid = 1'b1;
      in_data  = {1'b0, 3'b111, 12'($urandom), 1'b1, 3'b000, 12'($urandom)};
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || ovf !== 1'b0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b valid=%b ovf=%b data=%h, required all 0", busy, out_valid, ovf, out_data);
    end
    sym_coeff = '0;
    for (int k = 0; k < 64; k++) sym_data[k] = $urandom;
    run_symbol("after_reset", 0, 0, 1'b0);
  endtask

  task automatic test_start_in_emit();
    sym_coeff = rand_coeff();
    for (int k = 0; k < 64; k++) sym_data[k] = $urandom;
    run_symbol("start_in_emit", 0, 1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_codes();
    test_overflow();
    test_stall();
    test_random();
    test_reset_mid();
    test_start_in_emit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
